// File: rtl/sd_fifo_tail_pf_pkg.sv
// rtl/sd_fifo_tail_pf_pkg.sv - shared constants for the prefetching FIFO tail controller
package sd_fifo_tail_pf_pkg;

  localparam int unsigned PF_ENTRIES = 2;
  localparam int unsigned PF_CNT_W   = 2;

endpackage

// File: rtl/sd_pf_buf2.sv
// rtl/sd_pf_buf2.sv - 2-entry prefetch register FIFO with push, pop, flush and count
module sd_pf_buf2
  import sd_fifo_tail_pf_pkg::*;
#(
  parameter int width = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [width-1:0]    push_data,
  input  logic                pop,
  input  logic                flush,
  output logic [PF_CNT_W-1:0] count,
  output logic [width-1:0]    head_data
);

  logic [width-1:0]    ent_q [PF_ENTRIES];
  logic [width-1:0]    ent_d [PF_ENTRIES];
  logic                rd_idx_q, rd_idx_d;
  logic                wr_idx_q, wr_idx_d;
  logic [PF_CNT_W-1:0] count_q, count_d;

  always_comb begin
    ent_d    = ent_q;
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    count_d  = count_q;
    // Flush beats any push/pop in the same cycle so a rewind never keeps stale words
    if (flush) begin
      rd_idx_d = 1'b0;
      wr_idx_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push) begin
        ent_d[wr_idx_q] = push_data;
        wr_idx_d        = ~wr_idx_q;
      end
      if (pop) begin
        rd_idx_d = ~rd_idx_q;
      end
      count_d = count_q + PF_CNT_W'(push) - PF_CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_idx_q <= 1'b0;
      wr_idx_q <= 1'b0;
      count_q  <= '0;
    end else begin
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign count     = count_q;
  assign head_data = ent_q[rd_idx_q];

endmodule

// File: rtl/sd_fifo_tail_pf.sv
// rtl/sd_fifo_tail_pf.sv - read-side controller for a memory-based FIFO with 2-word prefetch
module sd_fifo_tail_pf
  import sd_fifo_tail_pf_pkg::*;
#(
  parameter int width     = 8,
  parameter int depth     = 256,
  parameter int rd_commit = 0,
  parameter int asz       = $clog2(depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [asz-1:0]   bound_low,
  input  logic [asz-1:0]   bound_high,
  input  logic [asz-1:0]   wrptr,
  output logic [asz-1:0]   cur_rdptr,
  output logic [asz-1:0]   com_rdptr,
  output logic             mem_re,
  input  logic [width-1:0] mem_rd_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  input  logic             p_commit,
  input  logic             p_abort,
  output logic [width-1:0] p_data,
  output logic [asz:0]     p_usage
);

  function automatic logic [asz-1:0] wrap_inc(input logic [asz-1:0] ptr,
                                              input logic [asz-1:0] lo,
                                              input logic [asz-1:0] hi);
    return (ptr == hi) ? lo : ptr + 1'b1;
  endfunction

  logic [asz-1:0]      cur_rdptr_q, cur_rdptr_d;
  logic [asz-1:0]      com_rdptr_q, com_rdptr_d;
  logic [asz-1:0]      pop_ptr_q, pop_ptr_d;
  logic                inflight_q, inflight_d;
  logic [asz:0]        p_usage_q, p_usage_d;
  logic [PF_CNT_W-1:0] buf_count;
  logic [width-1:0]    buf_head;
  logic                empty, xfer, do_abort, do_commit, buf_push;
  logic [2:0]          occupancy;
  logic [asz:0]        span;

  always_comb begin
    do_abort  = (rd_commit != 0) && p_abort;
    do_commit = (rd_commit != 0) && p_commit && !p_abort;
    p_srdy    = (buf_count != '0);
    xfer      = p_srdy & p_drdy;
    empty     = (cur_rdptr_q == wrptr);
    // Words buffered plus in flight, minus the one leaving now, must stay below two
    occupancy = 3'(buf_count) + 3'(inflight_q) - 3'(xfer);
    mem_re    = enable & !empty & !do_abort & (occupancy < 3'd2);
    buf_push  = inflight_q & !do_abort;
    inflight_d = mem_re;

    cur_rdptr_d = cur_rdptr_q;
    if (do_abort) begin
      cur_rdptr_d = com_rdptr_q;
    end else if (mem_re) begin
      cur_rdptr_d = wrap_inc(cur_rdptr_q, bound_low, bound_high);
    end

    pop_ptr_d = pop_ptr_q;
    if (do_abort) begin
      pop_ptr_d = com_rdptr_q;
    end else if (xfer) begin
      pop_ptr_d = wrap_inc(pop_ptr_q, bound_low, bound_high);
    end

    com_rdptr_d = com_rdptr_q;
    if (rd_commit == 0 || do_commit) begin
      com_rdptr_d = pop_ptr_d;
    end

    span = {1'b0, bound_high} - {1'b0, bound_low} + 1'b1;
    if (wrptr >= com_rdptr_q) begin
      p_usage_d = {1'b0, wrptr} - {1'b0, com_rdptr_q};
    end else begin
      p_usage_d = {1'b0, wrptr} - {1'b0, com_rdptr_q} + span;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_rdptr_q <= bound_low;
      com_rdptr_q <= bound_low;
      pop_ptr_q   <= bound_low;
      inflight_q  <= 1'b0;
      p_usage_q   <= '0;
    end else begin
      cur_rdptr_q <= cur_rdptr_d;
      com_rdptr_q <= com_rdptr_d;
      pop_ptr_q   <= pop_ptr_d;
      inflight_q  <= inflight_d;
      p_usage_q   <= p_usage_d;
    end
  end

  sd_pf_buf2 #(
    .width(width)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (buf_push),
    .push_data(mem_rd_data),
    .pop      (xfer),
    .flush    (do_abort),
    .count    (buf_count),
    .head_data(buf_head)
  );

  assign cur_rdptr = cur_rdptr_q;
  assign com_rdptr = com_rdptr_q;
  assign p_usage   = p_usage_q;
  assign p_data    = buf_head;

endmodule

// File: tb/tb_sd_fifo_tail_pf.sv
// tb/tb_sd_fifo_tail_pf.sv - self-checking bench for sd_fifo_tail_pf in both commit modes
module tb_sd_fifo_tail_pf;

  localparam int W = 8;
  localparam int D = 16;
  localparam int A = 4;

  logic         clk, reset, enable, p_drdy, p_commit, p_abort;
  logic [A-1:0] bound_low, bound_high, wrptr;
  logic [A-1:0] cur0, com0, cur1, com1;
  logic         mem_re0, mem_re1, p_srdy0, p_srdy1;
  logic [W-1:0] rd0, rd1, p_data0, p_data1;
  logic [A:0]   usage0, usage1;
  logic [W-1:0] mem [D];
  int           n_checks, n_fail;

  sd_fifo_tail_pf #(.width(W), .depth(D), .rd_commit(0)) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .bound_low(bound_low), .bound_high(bound_high),
    .wrptr(wrptr), .cur_rdptr(cur0), .com_rdptr(com0), .mem_re(mem_re0), .mem_rd_data(rd0),
    .p_srdy(p_srdy0), .p_drdy(p_drdy), .p_commit(p_commit), .p_abort(p_abort),
    .p_data(p_data0), .p_usage(usage0));

  sd_fifo_tail_pf #(.width(W), .depth(D), .rd_commit(1)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .bound_low(bound_low), .bound_high(bound_high),
    .wrptr(wrptr), .cur_rdptr(cur1), .com_rdptr(com1), .mem_re(mem_re1), .mem_rd_data(rd1),
    .p_srdy(p_srdy1), .p_drdy(p_drdy), .p_commit(p_commit), .p_abort(p_abort),
    .p_data(p_data1), .p_usage(usage1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_re0) rd0 <= mem[cur0];
    if (mem_re1) rd1 <= mem[cur1];
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [A-1:0] lo, input logic [A-1:0] hi);
    reset = 1'b1; bound_low = lo; bound_high = hi; wrptr = lo;
    enable = 1'b1; p_drdy = 1'b0; p_commit = 1'b0; p_abort = 1'b0;
    adv();
    adv();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(4'd0, 4'd7);
    #4;
    n_checks++; if (p_srdy0 !== 1'b0) begin n_fail++; $display("FAIL reset_srdy got %b exp 0", p_srdy0); end
    n_checks++; if (mem_re0 !== 1'b0) begin n_fail++; $display("FAIL reset_mem_re got %b exp 0", mem_re0); end
    n_checks++; if (cur0 !== 4'd0) begin n_fail++; $display("FAIL reset_cur got %0d exp 0", cur0); end
    n_checks++; if (com0 !== 4'd0) begin n_fail++; $display("FAIL reset_com got %0d exp 0", com0); end
    n_checks++; if (usage0 !== 5'd0) begin n_fail++; $display("FAIL reset_usage got %0d exp 0", usage0); end
    n_checks++; if (p_srdy1 !== 1'b0) begin n_fail++; $display("FAIL reset_srdy_c got %b exp 0", p_srdy1); end
    adv();
  endtask

  task automatic test_stream();
    logic [W-1:0] a [4];
    do_reset(4'd0, 4'd7);
    for (int i = 0; i < 4; i++) begin a[i] = W'($urandom); mem[i] = a[i]; end
    p_drdy = 1'b1;
    wrptr = 4'd4;
    for (int k = 0; k < 8; k++) begin
      #4;
      n_checks++; if (mem_re0 !== (k < 4)) begin n_fail++; $display("FAIL stream_mem_re c%0d got %b exp %b", k, mem_re0, k < 4); end
      if (k < 4) begin
        n_checks++; if (cur0 !== 4'(k)) begin n_fail++; $display("FAIL stream_addr c%0d got %0d exp %0d", k, cur0, k); end
      end
      n_checks++; if (p_srdy0 !== (k >= 2 && k <= 5)) begin n_fail++; $display("FAIL stream_srdy c%0d got %b", k, p_srdy0); end
      if (k >= 2 && k <= 5) begin
        n_checks++; if (p_data0 !== a[k-2]) begin n_fail++; $display("FAIL stream_data c%0d got %h exp %h", k, p_data0, a[k-2]); end
      end
      if (k == 1) begin
        n_checks++; if (usage0 !== 5'd4) begin n_fail++; $display("FAIL stream_usage_full got %0d exp 4", usage0); end
      end
      adv();
    end
    #4;
    n_checks++; if (com0 !== 4'd4) begin n_fail++; $display("FAIL stream_com got %0d exp 4", com0); end
    n_checks++; if (usage0 !== 5'd0) begin n_fail++; $display("FAIL stream_usage_end got %0d exp 0", usage0); end
    adv();
  endtask

  task automatic test_wrap();
    logic [W-1:0] b [3];
    logic [A-1:0] addrs [3];
    addrs[0] = 4'd6; addrs[1] = 4'd7; addrs[2] = 4'd4;
    do_reset(4'd4, 4'd7);
    mem[4] = W'($urandom); mem[5] = W'($urandom);
    p_drdy = 1'b1;
    wrptr = 4'd6;
    repeat (8) adv();
    #4;
    n_checks++; if (com0 !== 4'd6) begin n_fail++; $display("FAIL wrap_pre_com got %0d exp 6", com0); end
    adv();
    for (int i = 0; i < 3; i++) begin b[i] = W'($urandom); mem[addrs[i]] = b[i]; end
    wrptr = 4'd5;
    for (int k = 0; k < 8; k++) begin
      #4;
      if (k < 3) begin
        n_checks++; if (mem_re0 !== 1'b1 || cur0 !== addrs[k]) begin n_fail++; $display("FAIL wrap_fetch c%0d got re=%b addr=%0d exp addr=%0d", k, mem_re0, cur0, addrs[k]); end
      end
      if (k >= 2 && k <= 4) begin
        n_checks++; if (p_srdy0 !== 1'b1 || p_data0 !== b[k-2]) begin n_fail++; $display("FAIL wrap_data c%0d got %b/%h exp 1/%h", k, p_srdy0, p_data0, b[k-2]); end
      end
      adv();
    end
    #4;
    n_checks++; if (com0 !== 4'd5) begin n_fail++; $display("FAIL wrap_com got %0d exp 5", com0); end
    n_checks++; if (usage0 !== 5'd0) begin n_fail++; $display("FAIL wrap_usage got %0d exp 0", usage0); end
    adv();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a [4];
    int n_re;
    do_reset(4'd0, 4'd7);
    for (int i = 0; i < 4; i++) begin a[i] = W'($urandom); mem[i] = a[i]; end
    wrptr = 4'd4;
    n_re = 0;
    repeat (6) begin
      #4;
      n_re += int'(mem_re0);
      adv();
    end
    #4;
    n_checks++; if (n_re != 2) begin n_fail++; $display("FAIL bp_fetch_count got %0d exp 2", n_re); end
    n_checks++; if (mem_re0 !== 1'b0) begin n_fail++; $display("FAIL bp_mem_re got %b exp 0", mem_re0); end
    n_checks++; if (p_srdy0 !== 1'b1 || p_data0 !== a[0]) begin n_fail++; $display("FAIL bp_hold got %b/%h exp 1/%h", p_srdy0, p_data0, a[0]); end
    adv();
    p_drdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #4;
      if (k < 4) begin
        n_checks++; if (p_srdy0 !== 1'b1 || p_data0 !== a[k]) begin n_fail++; $display("FAIL bp_drain c%0d got %b/%h exp 1/%h", k, p_srdy0, p_data0, a[k]); end
      end else begin
        n_checks++; if (p_srdy0 !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b exp 0", p_srdy0); end
      end
      adv();
    end
    p_drdy = 1'b0;
  endtask

  task automatic test_abort();
    logic [W-1:0] a [4];
    bit got;
    do_reset(4'd0, 4'd7);
    for (int i = 0; i < 4; i++) begin a[i] = W'($urandom); mem[i] = a[i]; end
    p_drdy = 1'b1;
    wrptr = 4'd4;
    for (int k = 0; k < 5; k++) begin
      #4;
      if (k >= 2) begin
        n_checks++; if (p_data1 !== a[k-2]) begin n_fail++; $display("FAIL abort_pre c%0d got %h exp %h", k, p_data1, a[k-2]); end
      end
      adv();
    end
    p_abort = 1'b1;
    #4;
    n_checks++; if (p_srdy1 !== 1'b1 || p_data1 !== a[3]) begin n_fail++; $display("FAIL abort_cycle got %b/%h exp 1/%h", p_srdy1, p_data1, a[3]); end
    adv();
    p_abort = 1'b0;
    #4;
    n_checks++; if (com1 !== 4'd0) begin n_fail++; $display("FAIL abort_com got %0d exp 0", com1); end
    n_checks++; if (cur1 !== 4'd0) begin n_fail++; $display("FAIL abort_cur got %0d exp 0", cur1); end
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (p_srdy1) begin got = 1'b1; break; end
      adv();
      #4;
    end
    n_checks++; if (!got || p_data1 !== a[0]) begin n_fail++; $display("FAIL abort_replay got %b/%h exp 1/%h", got, p_data1, a[0]); end
    adv();
    p_commit = 1'b1;
    #4;
    n_checks++; if (p_srdy1 !== 1'b1 || p_data1 !== a[1]) begin n_fail++; $display("FAIL commit_data got %b/%h exp 1/%h", p_srdy1, p_data1, a[1]); end
    n_checks++; if (usage1 !== 5'd4) begin n_fail++; $display("FAIL commit_usage_pre got %0d exp 4", usage1); end
    adv();
    p_commit = 1'b0;
    p_drdy = 1'b0;
    adv();
    #4;
    n_checks++; if (com1 !== 4'd2) begin n_fail++; $display("FAIL commit_com got %0d exp 2", com1); end
    n_checks++; if (usage1 !== 5'd2) begin n_fail++; $display("FAIL commit_usage got %0d exp 2", usage1); end
    adv();
  endtask

  task automatic test_commit_abort_enable();
    logic [W-1:0] a [6];
    bit got;
    do_reset(4'd0, 4'd7);
    for (int i = 0; i < 6; i++) begin a[i] = W'($urandom); mem[i] = a[i]; end
    p_drdy = 1'b1;
    wrptr = 4'd6;
    #4;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (p_srdy1) begin got = 1'b1; break; end
      adv();
      #4;
    end
    n_checks++; if (!got || p_data1 !== a[0]) begin n_fail++; $display("FAIL ca_first got %b/%h exp 1/%h", got, p_data1, a[0]); end
    p_commit = 1'b1;
    adv();
    p_commit = 1'b0;
    for (int k = 1; k < 4; k++) begin
      #4;
      n_checks++; if (p_data1 !== a[k]) begin n_fail++; $display("FAIL ca_stream w%0d got %h exp %h", k, p_data1, a[k]); end
      adv();
    end
    p_commit = 1'b1;
    p_abort = 1'b1;
    #4;
    adv();
    p_commit = 1'b0;
    p_abort = 1'b0;
    p_drdy = 1'b0;
    #4;
    n_checks++; if (com1 !== 4'd1) begin n_fail++; $display("FAIL ca_com got %0d exp 1", com1); end
    n_checks++; if (cur1 !== 4'd1) begin n_fail++; $display("FAIL ca_cur got %0d exp 1", cur1); end
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (p_srdy1) begin got = 1'b1; break; end
      adv();
      #4;
    end
    n_checks++; if (!got || p_data1 !== a[1]) begin n_fail++; $display("FAIL ca_restart got %b/%h exp 1/%h", got, p_data1, a[1]); end
    repeat (4) adv();
    enable = 1'b0;
    p_drdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #4;
      n_checks++; if (mem_re1 !== 1'b0) begin n_fail++; $display("FAIL en_mem_re c%0d got %b exp 0", k, mem_re1); end
      if (k < 2) begin
        n_checks++; if (p_srdy1 !== 1'b1 || p_data1 !== a[1+k]) begin n_fail++; $display("FAIL en_drain c%0d got %b/%h exp 1/%h", k, p_srdy1, p_data1, a[1+k]); end
      end else begin
        n_checks++; if (p_srdy1 !== 1'b0) begin n_fail++; $display("FAIL en_empty got %b exp 0", p_srdy1); end
      end
      adv();
    end
    enable = 1'b1;
    #4;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (p_srdy1) begin got = 1'b1; break; end
      adv();
      #4;
    end
    n_checks++; if (!got || p_data1 !== a[3]) begin n_fail++; $display("FAIL en_resume got %b/%h exp 1/%h", got, p_data1, a[3]); end
    adv();
    p_drdy = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] q [$];
    logic [W-1:0] d, exp_d;
    int lo, sz, n_wr, n_pop, usage_lag;
    lo = 2; sz = 11; n_wr = 0; n_pop = 0; usage_lag = 0;
    do_reset(4'(lo), 4'(lo + sz - 1));
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (cyc < 600) begin
        if ((n_wr - n_pop) < (sz - 1) && $urandom_range(0, 2) != 0) begin
          d = W'($urandom);
          mem[lo + (n_wr % sz)] = d;
          q.push_back(d);
          n_wr++;
          wrptr = 4'(lo + (n_wr % sz));
        end
        p_drdy   = ($urandom_range(0, 3) != 0);
        enable   = ($urandom_range(0, 7) != 0);
        p_commit = ($urandom_range(0, 1) != 0);
        p_abort  = ($urandom_range(0, 5) == 0);
      end else begin
        p_drdy = 1'b1; enable = 1'b1; p_commit = 1'b0; p_abort = 1'b0;
      end
      #4;
      n_checks++; if (com0 !== 4'(lo + (n_pop % sz))) begin n_fail++; $display("FAIL rand_com c%0d got %0d exp %0d", cyc, com0, lo + (n_pop % sz)); end
      n_checks++; if (usage0 !== 5'(usage_lag)) begin n_fail++; $display("FAIL rand_usage c%0d got %0d exp %0d", cyc, usage0, usage_lag); end
      usage_lag = n_wr - n_pop;
      if (p_srdy0 && p_drdy) begin
        exp_d = (q.size() > 0) ? q[0] : 'x;
        n_checks++; if (q.size() == 0 || p_data0 !== exp_d) begin n_fail++; $display("FAIL rand_data c%0d got %h exp %h (pending %0d)", cyc, p_data0, exp_d, q.size()); end
        if (q.size() > 0) void'(q.pop_front());
        n_pop++;
      end
      adv();
    end
    n_checks++; if (n_pop != n_wr) begin n_fail++; $display("FAIL rand_drain got %0d words exp %0d", n_pop, n_wr); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; enable = 1'b1; p_drdy = 1'b0; p_commit = 1'b0; p_abort = 1'b0;
    bound_low = '0; bound_high = 4'd7; wrptr = '0;
    for (int i = 0; i < D; i++) mem[i] = '0;
    test_reset();
    test_stream();
    test_wrap();
    test_backpressure();
    test_abort();
    test_commit_abort_enable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
